// File: rtl/loom_axi_dma_master_if.sv
// loom_axi_dma_master_if: AXI4 full-width bus between the DMA master and its slave.
// Carries all five channels; parameters must match the master instance.
interface loom_axi_dma_master_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [2:0]              awprot;
  logic                    awlock;
  logic [3:0]              awcache;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [2:0]              arprot;
  logic                    arlock;
  logic [3:0]              arcache;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awprot, awlock, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arprot, arlock, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awprot, awlock, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arprot, arlock, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/loom_axi_dma_master.sv
// loom_axi_dma_master: single-descriptor AXI4 INCR burst DMA master.
// Define LOOM_DMA_4K_SPLIT_EN to keep every burst inside one 4 KiB page.
module loom_axi_dma_master #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0,
  parameter int MAX_BURST_BEATS = 16,
  parameter int BEATS_WIDTH     = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic                   desc_write_i,
  input  logic [ADDR_WIDTH-1:0]  desc_addr_i,
  input  logic [BEATS_WIDTH-1:0] desc_beats_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic [1:0]             done_resp_o,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  loom_axi_dma_master_if.master  m_axi
);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(BYTES);
  localparam int PAGE_BEATS = 4096 / BYTES;
`ifdef LOOM_DMA_4K_SPLIT_EN
  localparam bit SPLIT_4K = 1'b1;
`else
  localparam bit SPLIT_4K = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, AW, W, B, AR, R, DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BEATS_WIDTH-1:0] rem_q;
  logic [8:0]             len_q;
  logic [7:0]             axlen_q;
  logic [8:0]             beat_q;
  logic [1:0]             resp_q;
  logic                   desc_ready_q;

  // Burst length from the page offset (in beats) and beats still owed.
  function automatic logic [8:0] burst_len(
    input logic [11-LSB:0]      ofs,
    input logic [BEATS_WIDTH-1:0] rem
  );
    logic [31:0] n;
    logic [31:0] pg;
    n  = 32'(rem);
    pg = 32'(PAGE_BEATS) - 32'(ofs);
    if (n > 32'(MAX_BURST_BEATS)) n = 32'(MAX_BURST_BEATS);
    if (SPLIT_4K && n > pg) n = pg;
    return n[8:0];
  endfunction

  logic [ADDR_WIDTH-1:0]  addr_nx;
  logic [BEATS_WIDTH-1:0] rem_nx;
  logic [8:0]             len_first;
  logic [8:0]             len_nx;
  logic                   wlast;
  logic                   in_w;
  logic                   in_r;

  assign addr_nx   = addr_q + (ADDR_WIDTH'(len_q) << LSB);
  assign rem_nx    = rem_q - BEATS_WIDTH'(len_q);
  assign len_first = burst_len(desc_addr_i[11:LSB], desc_beats_i);
  assign len_nx    = burst_len(addr_nx[11:LSB], rem_nx);
  assign in_w      = (state == W);
  assign in_r      = (state == R);
  assign wlast     = in_w && (beat_q == len_q - 9'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      len_q        <= '0;
      axlen_q      <= '0;
      beat_q       <= '0;
      resp_q       <= 2'b00;
      desc_ready_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          desc_ready_q <= 1'b1;
          if (desc_valid_i && desc_ready_q) begin
            desc_ready_q <= 1'b0;
            addr_q       <= desc_addr_i;
            rem_q        <= desc_beats_i;
            resp_q       <= 2'b00;
            len_q        <= len_first;
            if (desc_beats_i == '0) begin
              state <= DONE;
            end else begin
              axlen_q <= 8'(len_first - 9'd1);
              state   <= desc_write_i ? AW : AR;
            end
          end
        end
        AW: begin
          beat_q <= '0;
          if (m_axi.awready) state <= W;
        end
        W: begin
          if (s_valid_i && m_axi.wready) begin
            beat_q <= beat_q + 9'd1;
            if (wlast) state <= B;
          end
        end
        B: begin
          if (m_axi.bvalid) begin
            if (m_axi.bresp != 2'b00 && resp_q == 2'b00)
              resp_q <= m_axi.bresp;
            addr_q  <= addr_nx;
            rem_q   <= rem_nx;
            len_q   <= len_nx;
            axlen_q <= 8'(len_nx - 9'd1);
            state   <= (rem_nx != '0) ? AW : DONE;
          end
        end
        AR: begin
          if (m_axi.arready) state <= R;
        end
        R: begin
          if (m_axi.rvalid && m_ready_i) begin
            if (m_axi.rresp != 2'b00 && resp_q == 2'b00)
              resp_q <= m_axi.rresp;
            if (m_axi.rlast) begin
              addr_q  <= addr_nx;
              rem_q   <= rem_nx;
              len_q   <= len_nx;
              axlen_q <= 8'(len_nx - 9'd1);
              state   <= (rem_nx != '0) ? AR : DONE;
            end
          end
        end
        DONE: begin
          if (done_ready_i) begin
            state        <= IDLE;
            desc_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign desc_ready_o  = desc_ready_q;
  assign done_valid_o  = (state == DONE);
  assign done_resp_o   = resp_q;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = axlen_q;
  assign m_axi.awsize  = 3'(LSB);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awvalid = (state == AW);

  // Write data is a straight pass-through of the source stream.
  assign m_axi.wdata   = in_w ? s_data_i : '0;
  assign m_axi.wstrb   = {BYTES{in_w}};
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = in_w && s_valid_i;
  assign s_ready_o     = in_w && m_axi.wready;
  assign m_axi.bready  = (state == B);

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = axlen_q;
  assign m_axi.arsize  = 3'(LSB);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arvalid = (state == AR);

  assign m_axi.rready  = in_r && m_ready_i;
  assign m_valid_o     = in_r && m_axi.rvalid;
  assign m_data_o      = in_r ? m_axi.rdata : '0;
  assign m_last_o      = in_r && m_axi.rlast &&
                         (rem_q == BEATS_WIDTH'(len_q));
endmodule

// File: doc/loom_axi_dma_master.md
# loom_axi_dma_master

Parametrised AXI4 full-width DMA master for the Loom shell. It turns single descriptors into INCR bursts on the m_axi_* bus, which the XDMA model currently ties to zero. Write descriptors stream data in from a valid/ready source; read descriptors stream data out to a valid/ready sink. It sits between the socket-BFM command path and the decoupler's AXI4 slave port, and completes each descriptor with a status handshake.

## Interface
Parameters:
- DATA_WIDTH, 128, AXI data width in bits; power of two, ≥32.
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant driven on awid/arid.
- MAX_BURST_BEATS, 16, beats per burst cap; power of two, 1..256.
- BEATS_WIDTH, 20, width of the descriptor beat count.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake.
- desc_write_i  in  1  selects direction: 1 = stream→AXI write, 0 = AXI read→stream.
- desc_addr_i  in  ADDR_WIDTH  start byte address; must be aligned to DATA_WIDTH/8.
- desc_beats_i  in  BEATS_WIDTH  beat count.
- done_valid_o / done_ready_i  out/in  1  completion handshake.
- done_resp_o  out  2  first non-OKAY response seen, else OKAY.
- s_data_i, s_valid_i, s_ready_o  in/in/out  DATA_WIDTH/1/1  write-data source.
- m_data_o, m_valid_o, m_ready_i, m_last_o  out/out/in/out  DATA_WIDTH/1/1/1  read-data sink.
- m_axi_aw*, w*, b*, ar*, r*  AXI4 master  full set: id, addr, len[7:0], size, burst, prot, lock, cache, data, strb, last, resp.

## Operation
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - desc_ready_o=1.
  - On accept: latch addr, remaining=beats, resp=OKAY.
  - beats==0 → DONE.
  - Otherwise write → AW, read → AR.
- Burst length: min(remaining, MAX_BURST_BEATS, beats to 4 KiB boundary when split enabled).
  - Beats to boundary = (4096 − addr[11:0]) / (DATA_WIDTH/8).
  - axlen = length − 1.
- AW: awvalid=1 until awready, then → W.
- W:
  - wvalid=s_valid_i and s_ready_o=wready; combinational pass-through, no buffering.
  - wstrb all ones. wlast on the burst's last beat.
  - After the last beat → B.
- B:
  - bready=1. On bvalid, bresp≠OKAY with resp still OKAY latches bresp.
  - Advance addr by length×bytes and decrement remaining.
  - remaining>0 → AW, else DONE.
- AR: arvalid=1 until arready, then → R.
- R:
  - m_valid_o=rvalid, rready=m_ready_i, m_data_o=rdata.
  - m_last_o=rlast && remaining==length.
  - First non-OKAY rresp latched. Advance on rlast as in B; → AR or DONE.
- DONE: done_valid_o=1 until done_ready_i, then → IDLE.
- Errors never abort: every beat is still transferred.
- Constant fields:
  - awsize/arsize=log2(DATA_WIDTH/8), burst=INCR (2'b01), cache=4'b0011, prot=0, lock=0.
  - id=AXI_ID.

## Timing
- Reset value of every output is 0: all valids, readies, desc_ready_o, done_valid_o, data and address.
- desc_ready_o rises the first cycle after reset release.
- Descriptor accepted at edge N → awvalid/arvalid high from cycle N+1.
- Only one burst is outstanding; the next AW/AR is issued the cycle after B or the final R beat.
- AW always completes before the first W beat.
- beats==0 → done_valid_o high the cycle after acceptance; no AXI traffic.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Descriptors crossing the top of the address space are undefined.
- Reset mid-burst clears state and valids immediately. Outstanding AXI transactions are abandoned; recovering the slave is the bench's responsibility.
- done_valid_o is held until accepted; no new descriptor is accepted meanwhile.

## Configuration
- LOOM_DMA_4K_SPLIT_EN defined: bursts never cross a 4 KiB boundary (AXI-compliant).
- Undefined: bursts split only at MAX_BURST_BEATS, for targets without the boundary rule.

## Test plan
- Write: 4 beats @0x1000, DATA_WIDTH=128 → one AW addr 0x1000 len 3; 4 W beats, wlast on 4th; done_resp OKAY.
- Read: 40 beats @0x0, MAX_BURST_BEATS=16 → AR len 15/15/7 at 0x0/0x100/0x200; m_last_o only on beat 40.
- Boundary: write 8 beats @0xFC0:
  - With LOOM_DMA_4K_SPLIT_EN → AW len 3 @0xFC0 and len 3 @0x1000.
  - Without it → single AW len 7 @0xFC0.
- Errors: read 32 beats, slave returns SLVERR (2'b10) on the second burst only → all 32 beats delivered; done_resp_o=2'b10.
- Zero-length: desc_beats_i=0 → done_valid_o the next cycle, awvalid/arvalid never asserted; then 1-beat write → awlen 0.
- Stress: random stall on s_valid_i/wready/m_ready_i during a 64-beat write and read → data order preserved, no drop or duplicate. rst_i pulsed mid-W → all outputs 0 asynchronously; desc_ready_o=1 after release.
